// File: rtl/cordic16_seq.sv
// cordic16_seq -- sequencer that drives an external cordic16 core through one
// complete rotation per request and captures its sin/cos result.
//
// Ports
//   clock, reset        sole clock (rising edge), asynchronous active-high reset
//   req_valid/req_angle request in; req_ready high exactly while IDLE
//   cd_endangle/cd_addr/cd_load/cd_clock   registered drive of the cordic16 core
//   cd_sin/cd_cos       cordic16 results, captured in CAPT
//   res_valid/res_ready result handshake; res_valid high exactly while DONE
//   res_sin/res_cos     last captured result, held until the next capture
//   dbg_state           current FSM state for observation
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a result transfers on a rising edge where res_valid && res_ready. Both ready
// and valid outputs are decoded from state only, so neither depends on inputs.
//
// Each iteration is a LOW/HIGH pair: LOW raises cd_clock, HIGH lowers it and
// advances cd_addr. cd_addr/cd_load therefore only move on edges that drive
// cd_clock low, and are stable across every cd_clock rise.
module cordic16_seq #(
  parameter int NITER = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [15:0] req_angle,
  output logic        req_ready,
  output logic [15:0] cd_endangle,
  output logic [3:0]  cd_addr,
  output logic        cd_load,
  output logic        cd_clock,
  input  logic [15:0] cd_sin,
  input  logic [15:0] cd_cos,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_sin,
  output logic [15:0] res_cos,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [3:0] LAST_ADDR = 4'(NITER - 1);

  state_t      state_q, state_d;
  logic [15:0] endangle_q, endangle_d;
  logic [3:0]  addr_q, addr_d;
  logic        load_q, load_d;
  logic        clk_q, clk_d;
  logic [15:0] sin_q, sin_d;
  logic [15:0] cos_q, cos_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      endangle_q <= 16'h0000;
      addr_q     <= 4'h0;
      load_q     <= 1'b0;
      clk_q      <= 1'b0;
      sin_q      <= 16'h0000;
      cos_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      endangle_q <= endangle_d;
      addr_q     <= addr_d;
      load_q     <= load_d;
      clk_q      <= clk_d;
      sin_q      <= sin_d;
      cos_q      <= cos_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    endangle_d = endangle_q;
    addr_d     = addr_q;
    load_d     = load_q;
    clk_d      = clk_q;
    sin_d      = sin_q;
    cos_d      = cos_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          endangle_d = req_angle;
          addr_d     = 4'h0;
          load_d     = 1'b1;
          clk_d      = 1'b0;
          state_d    = LOW;
        end
      end
      LOW: begin
        clk_d   = 1'b1;
        state_d = HIGH;
      end
      HIGH: begin
        clk_d  = 1'b0;
        load_d = 1'b0;
        // The last iteration leaves cd_addr at NITER-1 rather than wrapping.
        if (addr_q == LAST_ADDR) begin
          state_d = CAPT;
        end else begin
          addr_d  = addr_q + 4'd1;
          state_d = LOW;
        end
      end
      CAPT: begin
        sin_d   = cd_sin;
        cos_d   = cd_cos;
        state_d = DONE;
      end
      DONE: begin
        // A request seen together with res_ready is not taken here; IDLE
        // must be visited first.
        if (res_ready) begin
          addr_d  = 4'h0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign cd_endangle = endangle_q;
  assign cd_addr     = addr_q;
  assign cd_load     = load_q;
  assign cd_clock    = clk_q;
  assign res_sin     = sin_q;
  assign res_cos     = cos_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cordic16_seq.sv
// Testbench for cordic16_seq. Two instances: the default NITER=16 and NITER=4.
// Each instance drives a stand-in cordic16 device that folds load/addr/angle
// into its sin/cos outputs on every cd_clock rise; the expected result of an
// operation is modelled as a loop over the NITER iterations.
module tb_cordic16_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // NITER=16 instance
  logic        req_valid = 1'b0;
  logic [15:0] req_angle = 16'h0000;
  logic        req_ready;
  logic [15:0] cd_endangle;
  logic [3:0]  cd_addr;
  logic        cd_load;
  logic        cd_clock;
  logic [15:0] cd_sin;
  logic [15:0] cd_cos;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_sin;
  logic [15:0] res_cos;
  logic [2:0]  dbg_state;

  // NITER=4 instance
  logic        req_valid_4 = 1'b0;
  logic [15:0] req_angle_4 = 16'h0000;
  logic        req_ready_4;
  logic [15:0] cd_endangle_4;
  logic [3:0]  cd_addr_4;
  logic        cd_load_4;
  logic        cd_clock_4;
  logic [15:0] cd_sin_4;
  logic [15:0] cd_cos_4;
  logic        res_valid_4;
  logic        res_ready_4 = 1'b0;
  logic [15:0] res_sin_4;
  logic [15:0] res_cos_4;
  logic [2:0]  dbg_state_4;

  cordic16_seq u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
    .cd_endangle(cd_endangle), .cd_addr(cd_addr), .cd_load(cd_load), .cd_clock(cd_clock),
    .cd_sin(cd_sin), .cd_cos(cd_cos),
    .res_valid(res_valid), .res_ready(res_ready), .res_sin(res_sin), .res_cos(res_cos),
    .dbg_state(dbg_state)
  );

  cordic16_seq #(.NITER(4)) u_dut4 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_4), .req_angle(req_angle_4), .req_ready(req_ready_4),
    .cd_endangle(cd_endangle_4), .cd_addr(cd_addr_4), .cd_load(cd_load_4), .cd_clock(cd_clock_4),
    .cd_sin(cd_sin_4), .cd_cos(cd_cos_4),
    .res_valid(res_valid_4), .res_ready(res_ready_4), .res_sin(res_sin_4), .res_cos(res_cos_4),
    .dbg_state(dbg_state_4)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", tag, got, exp);
  endtask

  // ---------------- stand-in cordic16 devices ----------------
  function automatic logic [31:0] dev_step(input logic [31:0] sc, input logic [3:0] a);
    logic [15:0] s, c;
    s = {sc[30:16], sc[31]} + 16'(a) + 16'd1;
    c = sc[15:0] ^ (s << a) ^ 16'h5a5a;
    return {s, c};
  endfunction

  // Expected result of a whole operation: iterations 0..n-1, loaded on the first.
  function automatic logic [31:0] ref_result(input logic [15:0] angle, input int n);
    logic [31:0] sc;
    sc = {angle, ~angle};
    for (int i = 0; i < n; i++) sc = dev_step(sc, 4'(i));
    return sc;
  endfunction

  logic [31:0] dev_sc = '0;
  int          dev_rises = 0, dev_loads = 0, dev_max = 0, viol = 0;
  logic        p_clk = 1'b0, p_load = 1'b0;
  logic [3:0]  p_addr = 4'h0;
  assign cd_sin = dev_sc[31:16];
  assign cd_cos = dev_sc[15:0];

  // Sampled on the falling edge so the DUT's registered outputs are settled.
  always @(negedge clock) begin
    if (cd_clock && !p_clk) begin
      dev_sc = dev_step(cd_load ? {cd_endangle, ~cd_endangle} : dev_sc, cd_addr);
      dev_rises++;
      if (cd_load) dev_loads++;
      if (int'(cd_addr) > dev_max) dev_max = int'(cd_addr);
    end
    if (cd_clock && (cd_addr != p_addr || cd_load != p_load)) viol++;
    p_clk = cd_clock; p_addr = cd_addr; p_load = cd_load;
  end

  logic [31:0] dev_sc_4 = '0;
  int          dev_rises_4 = 0, dev_loads_4 = 0, dev_max_4 = 0;
  logic        p_clk_4 = 1'b0;
  assign cd_sin_4 = dev_sc_4[31:16];
  assign cd_cos_4 = dev_sc_4[15:0];

  always @(negedge clock) begin
    if (cd_clock_4 && !p_clk_4) begin
      dev_sc_4 = dev_step(cd_load_4 ? {cd_endangle_4, ~cd_endangle_4} : dev_sc_4, cd_addr_4);
      dev_rises_4++;
      if (cd_load_4) dev_loads_4++;
      if (int'(cd_addr_4) > dev_max_4) dev_max_4 = int'(cd_addr_4);
    end
    p_clk_4 = cd_clock_4;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] angle);
    exp_q.push_back(ref_result(angle, 16));
    dev_rises = 0; dev_loads = 0; dev_max = 0;
    req_valid = 1'b1;
    req_angle = angle;
    tick();
    req_valid = 1'b0;
    chk("busy_after_accept", {31'd0, req_ready}, 32'd0);
  endtask

  // Waits for res_valid (cycle count measured from the accepting edge) and
  // checks latency, device activity and the captured result.
  task automatic wait_result(input logic [15:0] angle, input int busy_at);
    int cyc;
    logic [31:0] exp;
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      if (busy_at > 0 && cyc == busy_at - 1) begin
        req_valid = 1'b1;
        req_angle = 16'h2a72;
      end
      tick();
      cyc++;
      if (req_valid) begin
        req_valid = 1'b0;
        chk("busy_endangle", {16'd0, cd_endangle}, {16'd0, angle});
      end
    end
    chk("latency", cyc, 33);
    chk("cd_clock_rises", dev_rises, 16);
    chk("cd_load_rises", dev_loads, 1);
    chk("cd_addr_max", dev_max, 15);
    chk("endangle_hold", {16'd0, cd_endangle}, {16'd0, angle});
    if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
    else begin
      exp = exp_q.pop_front();
      chk("result", {res_sin, res_cos}, exp);
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("idle_after_release", {30'd0, req_ready, res_valid}, 32'd2);
  endtask

  task automatic hold_result(input int n);
    logic [31:0] held;
    held = {res_sin, res_cos};
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b1;
      req_angle = 16'($urandom);
      tick();
      chk("bp_valid_ready", {30'd0, res_valid, req_ready}, 32'd2);
      chk("bp_result_stable", {res_sin, res_cos}, held);
    end
    req_valid = 1'b0;
    chk("bp_no_extra_op", dev_rises, 16);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] a;
    logic [31:0] exp4;
    int cyc;

    #1;
    chk("reset_outputs", {cd_endangle, cd_addr, cd_load, cd_clock, req_ready, res_valid, 10'd0},
        {16'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0});
    chk("reset_result", {res_sin, res_cos}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Basic operation with a busy request at cycle 8, then backpressure.
    send(16'h2500);
    wait_result(16'h2500, 8);
    hold_result(10);
    release_result();

    // Back-to-back: release and request together, accepted one edge later.
    send(16'h1234);
    wait_result(16'h1234, 0);
    res_ready = 1'b1;
    req_valid = 1'b1;
    req_angle = 16'h6789;
    tick();
    res_ready = 1'b0;
    chk("b2b_idle_only", {30'd0, req_ready, cd_load}, 32'd2);
    exp_q.push_back(ref_result(16'h6789, 16));
    dev_rises = 0; dev_loads = 0; dev_max = 0;
    tick();
    req_valid = 1'b0;
    chk("b2b_accepted", {31'd0, cd_load}, 32'd1);
    wait_result(16'h6789, 0);
    release_result();

    // Mid-operation reset at cycle 10.
    send(16'h0f0f);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {cd_endangle, cd_addr, cd_load, cd_clock, req_ready, res_valid, 10'd0},
        {16'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0});
    chk("midreset_result", {res_sin, res_cos}, 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    send(16'h2500);
    wait_result(16'h2500, 0);
    release_result();

    // Randomized operations with random result backpressure.
    for (int k = 0; k < 6; k++) begin
      a = 16'($urandom);
      send(a);
      wait_result(a, 0);
      hold_result($urandom_range(0, 3));
      release_result();
    end

    // NITER=4 instance.
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 16'h2500 : 16'($urandom);
      exp4 = ref_result(a, 4);
      dev_rises_4 = 0; dev_loads_4 = 0; dev_max_4 = 0;
      req_valid_4 = 1'b1;
      req_angle_4 = a;
      tick();
      req_valid_4 = 1'b0;
      cyc = 0;
      while (!res_valid_4 && cyc < 100) begin
        tick();
        cyc++;
      end
      chk("n4_latency", cyc, 9);
      chk("n4_rises", dev_rises_4, 4);
      chk("n4_loads", dev_loads_4, 1);
      chk("n4_addr_max", dev_max_4, 3);
      chk("n4_result", {res_sin_4, res_cos_4}, exp4);
      res_ready_4 = 1'b1;
      tick();
      res_ready_4 = 1'b0;
      chk("n4_idle", {30'd0, req_ready_4, res_valid_4}, 32'd2);
    end

    chk("addr_load_stable", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
